// File: rtl/pong_timing_pkg.sv
// Shared constants for the Pong video timing block: counter width and the
// default horizontal/vertical raster geometry.
package pong_timing_pkg;
  localparam int CNT_W = 9;

  localparam int DEF_H_TOTAL      = 455;
  localparam int DEF_H_BLANK_END  = 80;
  localparam int DEF_H_SYNC_START = 32;
  localparam int DEF_H_SYNC_END   = 64;
  localparam int DEF_V_TOTAL      = 262;
  localparam int DEF_V_BLANK_END  = 16;
  localparam int DEF_V_SYNC_START = 4;
  localparam int DEF_V_SYNC_END   = 8;
endpackage

// File: rtl/pong_video_timing_if.sv
// Raster timing bundle: counters plus the sync/blank/start strobes that feed
// the chip models and the video output stage.
interface pong_video_timing_if;
  logic [pong_timing_pkg::CNT_W-1:0] hcnt;
  logic [pong_timing_pkg::CNT_W-1:0] vcnt;
  logic hblank;
  logic vblank;
  logic hsync;
  logic vsync;
  logic line_start;
  logic frame_start;
  logic video_de;

  modport master (output hcnt, vcnt, hblank, vblank, hsync, vsync,
                  line_start, frame_start, video_de);
  modport slave  (input  hcnt, vcnt, hblank, vblank, hsync, vsync,
                  line_start, frame_start, video_de);
endinterface

// File: rtl/pong_sync_window.sv
// One registered active window [START, END) decoded from the next counter
// value, so the output lines up with the counter register it accompanies.
module pong_sync_window
  import pong_timing_pkg::*;
#(
  parameter int START   = 0,
  parameter int END     = 1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] next_cnt,
  output logic             active
);
  localparam logic [CNT_W:0] LO  = START[CNT_W:0];
  localparam logic [CNT_W:0] LEN = END[CNT_W:0] - START[CNT_W:0];

  // Single unsigned compare: counts below LO wrap to >= 512, which is never
  // inside a window of length <= 511 starting above zero.
  logic [CNT_W:0] offs;
  assign offs = {1'b0, next_cnt} - LO;

  // Window register, updated only on pixel enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  active <= RST_VAL;
    else if (en) active <= (offs < LEN);
  end
endmodule

// File: rtl/pong_video_timing.sv
// H/V raster counter chain with registered sync, blank and start strobes,
// advanced by the pixel clock enable.
module pong_video_timing
  import pong_timing_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_BLANK_END  = DEF_H_BLANK_END,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_BLANK_END  = DEF_V_BLANK_END,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_pix,
  pong_video_timing_if.master  vid
);
  if (H_TOTAL > 512 || H_TOTAL < 2 || H_SYNC_START < 0 ||
      H_SYNC_START >= H_SYNC_END || H_SYNC_END > H_TOTAL ||
      H_BLANK_END < 1 || H_BLANK_END > H_TOTAL) begin : g_bad_h
    $error("pong_video_timing: illegal horizontal timing parameters");
  end
  if (V_TOTAL > 512 || V_TOTAL < 2 || V_SYNC_START < 0 ||
      V_SYNC_START >= V_SYNC_END || V_SYNC_END > V_TOTAL ||
      V_BLANK_END < 1 || V_BLANK_END > V_TOTAL) begin : g_bad_v
    $error("pong_video_timing: illegal vertical timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] hcnt_q, vcnt_q, hcnt_n, vcnt_n;
  logic             h_wrap, ls_q, fs_q;

  // Next-count decode; the windows below register from these values.
  always_comb begin
    hcnt_n = hcnt_q;
    vcnt_n = vcnt_q;
    h_wrap = (hcnt_q == H_LAST);
    if (ce_pix) begin
      hcnt_n = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) vcnt_n = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Counter and start-pulse registers; pulses drop on any non-enable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_n;
      vcnt_q <= vcnt_n;
      ls_q   <= ce_pix & h_wrap;
      fs_q   <= ce_pix & h_wrap & (vcnt_q == V_LAST);
    end
  end

  pong_sync_window #(.START(0), .END(H_BLANK_END), .RST_VAL(1'b1)) u_hblank (
    .clk(clk), .rst_n(rst_n), .en(ce_pix), .next_cnt(hcnt_n), .active(vid.hblank));
  pong_sync_window #(.START(H_SYNC_START), .END(H_SYNC_END), .RST_VAL(1'b0)) u_hsync (
    .clk(clk), .rst_n(rst_n), .en(ce_pix), .next_cnt(hcnt_n), .active(vid.hsync));
  pong_sync_window #(.START(0), .END(V_BLANK_END), .RST_VAL(1'b1)) u_vblank (
    .clk(clk), .rst_n(rst_n), .en(ce_pix), .next_cnt(vcnt_n), .active(vid.vblank));
  pong_sync_window #(.START(V_SYNC_START), .END(V_SYNC_END), .RST_VAL(1'b0)) u_vsync (
    .clk(clk), .rst_n(rst_n), .en(ce_pix), .next_cnt(vcnt_n), .active(vid.vsync));

  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;
  assign vid.video_de    = ~(vid.hblank | vid.vblank);
endmodule
